// File: rtl/regbank_p4_pkg.sv
// Shared definitions for the 4-register bank and its instruction issuer.
//   - Opcode constants, which the bank decodes and the issuer validates.
//   - Instruction field positions: opcode [11:8], immediate [7:0].
//   - Issuer FSM state encoding.
//   - opcode_legal(): true for the opcodes the bank understands.
package regbank_p4_pkg;

   localparam int INST_W  = 12;
   localparam int OPC_MSB = 11;
   localparam int OPC_LSB = 8;
   localparam int IMM_MSB = 7;
   localparam int IMM_LSB = 0;

   localparam logic [3:0] OPC_NOP = 4'd0;
   localparam logic [3:0] OPC_LD0 = 4'd1;
   localparam logic [3:0] OPC_LD1 = 4'd2;
   localparam logic [3:0] OPC_LD2 = 4'd3;
   localparam logic [3:0] OPC_LD3 = 4'd4;

   typedef enum logic [2:0] {
      ST_RESET = 3'd0,
      ST_IDLE  = 3'd1,
      ST_ISSUE = 3'd2,
      ST_GAP   = 3'd3,
      ST_ERROR = 3'd4
   } issuer_state_e;

   // Opcodes are contiguous from NOP up to LD3.
   function automatic logic opcode_legal(input logic [3:0] opc);
      return (opc <= OPC_LD3);
   endfunction

endpackage

// File: rtl/inst_fifo_p4.sv
// Synchronous instruction FIFO, DEPTH x INST_W bits.
// Ports:
//   i_clock    clock, rising edge
//   i_rst_n    asynchronous active-low reset (empties the FIFO)
//   i_flush    synchronous discard of all contents
//   i_push     write i_wr_data (ignored when full unless a pop happens too)
//   i_wr_data  entry to write
//   i_pop      advance the head (ignored when empty)
//   o_rd_data  current head entry (combinational read)
//   o_full     count == DEPTH
//   o_empty    count == 0
//   o_count    occupancy, 0..DEPTH
// Pointers are log2(DEPTH) bits and wrap naturally; the separate count
// is what tells full from empty when the pointers are equal.
module inst_fifo_p4
   import regbank_p4_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int CW    = 5
) (
   input  logic              i_clock,
   input  logic              i_rst_n,
   input  logic              i_flush,
   input  logic              i_push,
   input  logic [INST_W-1:0] i_wr_data,
   input  logic              i_pop,
   output logic [INST_W-1:0] o_rd_data,
   output logic              o_full,
   output logic              o_empty,
   output logic [CW-1:0]     o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [INST_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;

   logic w_do_push;
   logic w_do_pop;

   assign w_do_pop  = i_pop && (r_count != '0);
   // A push into a full FIFO is only safe when the head leaves in the same cycle.
   assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

   always_ff @(posedge i_clock or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
      end
   end

   // Storage needs no reset; only entries below the count are ever read.
   always_ff @(posedge i_clock) begin
      if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_wr_data;
   end

   assign o_rd_data = r_mem[r_rd_ptr];
   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;

endmodule

// File: rtl/inst_issuer_p4.sv
// Instruction issuer for the 4-register bank.
// Buffers {opcode, imm} instructions from a host and plays them out to
// the bank on command, optionally spacing them by GAP idle cycles.
// Ports:
//   clock       clock, rising edge
//   reset       asynchronous active-low reset
//   load_inst   instruction to append ([11:8] opcode, [7:0] imm)
//   load_en     append load_inst this cycle
//   load_ready  buffer has room and the issuer is not in Reset/Error
//   start       single-cycle pulse: play out the buffer
//   inst        instruction to the bank (0 whenever inst_en is low)
//   inst_en     inst valid this cycle
//   busy        a run is in progress (Issue or Gap)
//   done        one-cycle pulse when a run finishes (or start on empty)
//   err         sticky: illegal opcode or overflow seen since reset
//   count       buffer occupancy
// Handshakes: load_en is a request that the issuer samples every active
// cycle; a load while load_ready is low is an error, not a stall, so
// the host must honour load_ready. inst_en is a one-cycle strobe with no
// back-pressure; the bank takes inst on every cycle inst_en is high.
// All outputs are registers, derived from the next state at each edge;
// r_state is the observable FSM state.
module inst_issuer_p4
   import regbank_p4_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int GAP   = 0,
   parameter int CW    = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [INST_W-1:0] load_inst,
   input  logic              load_en,
   output logic              load_ready,
   input  logic              start,
   output logic [INST_W-1:0] inst,
   output logic              inst_en,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [CW-1:0]     count
);

   issuer_state_e r_state;
   issuer_state_e w_state_nxt;
   logic [3:0]    r_gap;
   logic [3:0]    w_gap_nxt;

   logic [INST_W-1:0] r_inst;
   logic              r_inst_en;
   logic              r_busy;
   logic              r_done;
   logic              r_err;
   logic              r_load_ready;

   logic              w_active;
   logic              w_opc_ok;
   logic              w_load_err;
   logic              w_push;
   logic              w_pop;
   logic              w_done_nxt;
   logic              w_full;
   logic              w_empty;
   logic [INST_W-1:0] w_head;
   logic [CW-1:0]     w_count;
   logic [CW-1:0]     w_count_nxt;
   logic              w_nxt_busy;
   logic              w_nxt_active;

   assign w_active   = (r_state == ST_IDLE) || (r_state == ST_ISSUE) || (r_state == ST_GAP);
   assign w_opc_ok   = opcode_legal(load_inst[OPC_MSB:OPC_LSB]);
   assign w_load_err = w_active && load_en && (!w_opc_ok || w_full);
   assign w_push     = w_active && load_en && !w_load_err;

   inst_fifo_p4 #(
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_fifo (
      .i_clock   (clock),
      .i_rst_n   (reset),
      .i_flush   (w_load_err),
      .i_push    (w_push),
      .i_wr_data (load_inst),
      .i_pop     (w_pop),
      .o_rd_data (w_head),
      .o_full    (w_full),
      .o_empty   (w_empty),
      .o_count   (w_count)
   );

   // Issue state = the cycle inst_en is high; the pop that feeds it is
   // decided one cycle earlier. Gap counts down the idle cycles; a run
   // ends at the end of an Issue cycle that finds the buffer empty.
   always_comb begin
      w_state_nxt = r_state;
      w_gap_nxt   = r_gap;
      w_pop       = 1'b0;
      w_done_nxt  = 1'b0;
      case (r_state)
         ST_RESET: begin
            w_state_nxt = ST_IDLE;
         end
         ST_IDLE: begin
            if (start) begin
               if (!w_empty) begin
                  w_pop       = 1'b1;
                  w_state_nxt = ST_ISSUE;
               end else begin
                  w_done_nxt = 1'b1;
               end
            end
         end
         ST_ISSUE: begin
            if (w_empty && !w_push) begin
               w_state_nxt = ST_IDLE;
               w_done_nxt  = 1'b1;
            end else if (GAP > 0) begin
               w_state_nxt = ST_GAP;
               w_gap_nxt   = 4'(GAP - 1);
            end else if (!w_empty) begin
               w_pop       = 1'b1;
            end else begin
               // GAP=0 but the only entry arrives now: wait one cycle in Gap
               // so it can be popped once it is actually stored.
               w_state_nxt = ST_GAP;
               w_gap_nxt   = 4'd0;
            end
         end
         ST_GAP: begin
            if (r_gap != 4'd0) begin
               w_gap_nxt = r_gap - 4'd1;
            end else if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = ST_ISSUE;
            end else if (!w_push) begin
               w_state_nxt = ST_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         ST_ERROR: begin
            w_state_nxt = ST_ERROR;
         end
         default: begin
            w_state_nxt = ST_ERROR;
         end
      endcase
      // A bad load wins over everything, including a pop in this cycle.
      if (w_load_err) begin
         w_state_nxt = ST_ERROR;
         w_pop       = 1'b0;
         w_done_nxt  = 1'b0;
      end
   end

   assign w_count_nxt  = w_load_err ? '0 : (w_count + CW'(w_push) - CW'(w_pop));
   assign w_nxt_busy   = (w_state_nxt == ST_ISSUE) || (w_state_nxt == ST_GAP);
   assign w_nxt_active = w_nxt_busy || (w_state_nxt == ST_IDLE);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_RESET;
         r_gap        <= 4'd0;
         r_inst       <= '0;
         r_inst_en    <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_load_ready <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_gap        <= w_gap_nxt;
         r_inst_en    <= w_pop;
         r_inst       <= w_pop ? w_head : '0;
         r_busy       <= w_nxt_busy;
         r_done       <= w_done_nxt;
         r_err        <= (w_state_nxt == ST_ERROR);
         r_load_ready <= w_nxt_active && (w_count_nxt != CW'(DEPTH));
      end
   end

   assign inst       = r_inst;
   assign inst_en    = r_inst_en;
   assign busy       = r_busy;
   assign done       = r_done;
   assign err        = r_err;
   assign load_ready = r_load_ready;
   assign count      = w_count;

endmodule
